add_sub_accumulator: RTL

Sequencing and accumulator stage built around the 3-bit two's-complement add/subtract unit. It accepts operations over a valid/ready input stream and drives the adder's a, b and m inputs. a comes from the internal accumulator, b and m come from the latched request. It captures result and overflow back into the accumulator, then presents each updated value on a valid/ready output stream with per-op and sticky overflow flags. It instantiates add_subtract internally and is the block that both feeds it and consumes its result/overflow.

---
 rtl/add_sub_accumulator.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/add_sub_accumulator.sv
// Accumulator stage that sequences requests into a 3-bit two's-complement add/subtract unit
// and presents each updated accumulator value on a valid/ready stream with overflow flags.

module add_subtract #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_m,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_cin;

    // Subtract as a + ~b + 1
    assign w_b_eff = i_b ^ {WIDTH{i_m}};
    assign w_cin   = {{(WIDTH-1){1'b0}}, i_m};
    assign o_sum   = i_a + w_b_eff + w_cin;
    assign o_ovf   = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

module add_sub_accumulator #(
    parameter int unsigned WIDTH    = 3,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_ovf,
    output logic             sticky_ovf,
    input  logic             clr_sticky
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    localparam logic [1:0] OpAdd  = 2'b00;
    localparam logic [1:0] OpSub  = 2'b01;
    localparam logic [1:0] OpLoad = 2'b10;

    localparam logic [WIDTH-1:0] SatPos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SatNeg = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic             r_valid;
    logic             r_sticky;

    logic             w_sub;
    logic [WIDTH-1:0] w_sum;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_acc_d;
    logic             w_ovf_d;

    assign w_sub = (r_op == OpSub);

    add_subtract #(
        .WIDTH(WIDTH)
    ) u_add_subtract (
        .i_a  (r_acc),
        .i_b  (r_data),
        .i_m  (w_sub),
        .o_sum(w_sum),
        .o_ovf(w_add_ovf)
    );

    always_comb begin
        w_acc_d = r_acc;
        w_ovf_d = 1'b0;
        case (r_op)
            OpAdd, OpSub: begin
                w_ovf_d = w_add_ovf;
                // Overflow direction follows the sign of the accumulator before the op
                if (SATURATE && w_add_ovf) begin
                    w_acc_d = r_acc[WIDTH-1] ? SatNeg : SatPos;
                end else begin
                    w_acc_d = w_sum;
                end
            end
            OpLoad:  w_acc_d = r_data;
            default: w_acc_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_op     <= 2'b00;
            r_data   <= '0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_op    <= in_op;
                        r_data  <= in_data;
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    r_acc   <= w_acc_d;
                    r_ovf   <= w_ovf_d;
                    r_valid <= 1'b1;
                    r_state <= StHold;
                end
                StHold: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase

            // A new overflow takes priority over a simultaneous clear request
            if (r_state == StExec && w_ovf_d) begin
                r_sticky <= 1'b1;
            end else if (clr_sticky) begin
                r_sticky <= 1'b0;
            end
        end
    end

    assign in_ready   = (r_state == StIdle);
    assign out_valid  = r_valid;
    assign out_acc    = r_acc;
    assign out_ovf    = r_ovf;
    assign sticky_ovf = r_sticky;

endmodule
